// File: rtl/bg_scroll_scheduler.sv
// Frame-synchronous scheduler for three scrolling background layers: per-layer
// scroll offsets advanced on each vsync rising edge, plus a one-hot layer select FSM.

module bg_scroll_lane #(
  parameter int H_WRAP = 640,
  parameter int OFF_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       spd,
  input  logic             dir,
  output logic [OFF_W-1:0] off
);
  localparam logic [OFF_W:0] WRAP = (OFF_W+1)'(H_WRAP);

  logic [OFF_W:0] ext, diff, res;

  assign ext = {1'b0, off};

  // One extra bit: a set MSB after subtraction means the offset went negative.
  always_comb begin
    if (dir) begin
      diff = ext - (OFF_W+1)'(spd);
      res  = diff[OFF_W] ? diff + WRAP : diff;
    end else begin
      diff = ext + (OFF_W+1)'(spd);
      res  = (diff >= WRAP) ? diff - WRAP : diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     off <= '0;
    else if (en) off <= res[OFF_W-1:0];
  end
endmodule

module bg_scroll_scheduler #(
  parameter int H_WRAP  = 640,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [2:0] layer_sel,
  output logic [9:0] scroll_x0,
  output logic [9:0] scroll_x1,
  output logic [9:0] scroll_x2,
  output logic       frame_tick,
  output logic       switch_irq
);
  localparam int NUM_LAYERS = 3;
  localparam int OFF_W      = 10;

  typedef struct packed {
    logic               run;
    logic               auto_en;
    logic [2:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, MANUAL, SHOW, BLANK} state_t;

  ctrl_t                            ctrl;
  logic [NUM_LAYERS-1:0][4:0]       speed;
  logic [NUM_LAYERS-1:0][OFF_W-1:0] offs;

  logic vsync_q, armed;

  state_t             state, state_d;
  logic [1:0]         cur, cur_d, nxt, nxt_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [2:0]         sel_d;
  logic               irq_d;
  logic               reenter;
  logic [2:0]         nab;

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else           lowest = 2'd2;
  endfunction

  // {found, index} of the next mask bit above c, wrapping, never c itself.
  function automatic logic [2:0] next_above(input logic [1:0] c, input logic [2:0] m);
    logic [1:0] c1, c2;
    c1 = (c == 2'd2) ? 2'd0 : c + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    next_above = 3'b000;
    if (m[c1])      next_above = {1'b1, c1};
    else if (m[c2]) next_above = {1'b1, c2};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl  <= '0;
      speed <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0: begin
          ctrl.run     <= wr_data[0];
          ctrl.auto_en <= wr_data[1];
          ctrl.mask    <= wr_data[4:2];
        end
        3'd1:    ctrl.dwell <= DWELL_W'(wr_data);
        3'd2:    speed[0]   <= wr_data[4:0];
        3'd3:    speed[1]   <= wr_data[4:0];
        3'd4:    speed[2]   <= wr_data[4:0];
        3'd5:    ctrl.sel   <= wr_data[1:0];
        default: ;
      endcase
    end
  end

  // armed blocks a tick from a vsync that was already high at reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      if (!vsync) armed <= 1'b1;
      frame_tick <= vsync & ~vsync_q & armed;
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
    bg_scroll_lane #(.H_WRAP(H_WRAP), .OFF_W(OFF_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (frame_tick & ctrl.run),
      .spd (speed[i][3:0]),
      .dir (speed[i][4]),
      .off (offs[i])
    );
  end

  assign scroll_x0 = offs[0];
  assign scroll_x1 = offs[1];
  assign scroll_x2 = offs[2];

  assign nab     = next_above(cur, ctrl.mask);
  assign reenter = (state == IDLE)
                || (state == MANUAL && ctrl.auto_en)
                || ((state == SHOW || state == BLANK) && !ctrl.auto_en);

  always_comb begin
    state_d = state;
    cur_d   = cur;
    nxt_d   = nxt;
    cnt_d   = cnt;
    sel_d   = layer_sel;
    irq_d   = 1'b0;
    if (frame_tick) begin
      if (!ctrl.run) begin
        state_d = IDLE;
      end else if (reenter) begin
        if (!ctrl.auto_en) begin
          state_d = MANUAL;
        end else if (ctrl.mask != 3'b000) begin
          state_d = SHOW;
          cur_d   = lowest(ctrl.mask);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        case (state)
          SHOW: begin
            if (ctrl.mask == 3'b000) begin
              state_d = IDLE;
            end else if (!ctrl.mask[cur]) begin
              cur_d = lowest(ctrl.mask);
              cnt_d = '0;
            end else if (ctrl.dwell != '0 && cnt + DWELL_W'(1) == ctrl.dwell) begin
              if (nab[2]) begin
                nxt_d   = nab[1:0];
                state_d = BLANK;
              end else begin
                cnt_d = '0;
              end
            end else begin
              cnt_d = cnt + DWELL_W'(1);
            end
          end
          BLANK: begin
            cur_d   = nxt;
            cnt_d   = '0;
            state_d = SHOW;
            irq_d   = 1'b1;
          end
          default: ;
        endcase
      end
      case (state_d)
        MANUAL:  sel_d = onehot(ctrl.sel);
        SHOW:    sel_d = onehot(cur_d);
        default: sel_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= 2'd0;
      nxt        <= 2'd0;
      cnt        <= '0;
      layer_sel  <= 3'b000;
      switch_irq <= 1'b0;
    end else begin
      state      <= state_d;
      cur        <= cur_d;
      nxt        <= nxt_d;
      cnt        <= cnt_d;
      layer_sel  <= sel_d;
      switch_irq <= irq_d;
    end
  end
endmodule

// File: tb/tb_bg_scroll_scheduler.sv
// Scoreboard bench: each vsync pulse queues the expected post-tick outputs;
// the monitor checks them one cycle after frame_tick.

module tb_bg_scroll_scheduler;
  logic       clk = 1'b0;
  logic       rst, vsync, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] layer_sel;
  logic [9:0] scroll_x0, scroll_x1, scroll_x2;
  logic       frame_tick, switch_irq;

  typedef struct {
    int         id;
    logic [2:0] sel;
    logic [9:0] x0, x1, x2;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  bg_scroll_scheduler #(.H_WRAP(640), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .layer_sel  (layer_sel),
    .scroll_x0  (scroll_x0),
    .scroll_x1  (scroll_x1),
    .scroll_x2  (scroll_x2),
    .frame_tick (frame_tick),
    .switch_irq (switch_irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Optional register write lands in the same cycle frame_tick is high.
  task automatic pulse(input logic [2:0] sel, input int x0, input int x1, input int x2,
                       input logic irq, input bit dw = 1'b0,
                       input logic [2:0] a = 3'd0, input logic [7:0] d = 8'd0);
    exp_t e;
    e.id = vec_id; e.sel = sel; e.irq = irq;
    e.x0 = 10'(x0); e.x1 = 10'(x1); e.x2 = 10'(x2);
    vec_id++;
    q.push_back(e);
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    if (dw) begin wr_en = 1'b1; wr_addr = a; wr_data = d; end
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); vsync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    n_cmp++;
    if ({layer_sel, scroll_x0, scroll_x1, scroll_x2, frame_tick, switch_irq} !== '0) begin
      n_bad++;
      $display("FAIL %s: sel=%b x0=%0d x1=%0d x2=%0d tick=%b irq=%b, required all zero",
               nm, layer_sel, scroll_x0, scroll_x1, scroll_x2, frame_tick, switch_irq);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        @(negedge clk);
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_tick: sel=%b x0=%0d, no expectation queued", layer_sel, scroll_x0);
        end else begin
          e = q.pop_front();
          if (layer_sel !== e.sel || scroll_x0 !== e.x0 || scroll_x1 !== e.x1 ||
              scroll_x2 !== e.x2 || switch_irq !== e.irq) begin
            n_bad++;
            $display("FAIL tick%0d: got sel=%b x=%0d/%0d/%0d irq=%b, required sel=%b x=%0d/%0d/%0d irq=%b",
                     e.id, layer_sel, scroll_x0, scroll_x1, scroll_x2, switch_irq,
                     e.sel, e.x0, e.x1, e.x2, e.irq);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    bit seen;
    rst = 1'b1; vsync = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_state");

    // Manual mode, SEL=0, layer 0 at +5 px/frame.
    wr(3'd0, 8'h01);
    wr(3'd2, 8'h05);
    pulse(3'b001, 5, 0, 0, 1'b0);
    pulse(3'b001, 10, 0, 0, 1'b0);
    pulse(3'b001, 15, 0, 0, 1'b0);

    // Wrap in both directions on layer 1.
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    pulse(3'b001, 15, 1, 0, 1'b0);
    wr(3'd3, 8'h13);
    pulse(3'b001, 15, 638, 0, 1'b0);
    pulse(3'b001, 15, 635, 0, 1'b0);
    wr(3'd3, 8'h0F);
    pulse(3'b001, 15, 10, 0, 1'b0);
    wr(3'd3, 8'h00);
    wr(3'd5, 8'h02);
    pulse(3'b100, 15, 10, 0, 1'b0);
    wr(3'd5, 8'h03);
    pulse(3'b000, 15, 10, 0, 1'b0);

    // Auto rotation over all three layers, dwell 2; layer 2 scrolls -1 from 0.
    wr(3'd4, 8'h11);
    wr(3'd0, 8'h1F);
    wr(3'd1, 8'h02);
    pulse(3'b001, 15, 10, 639, 1'b0);
    pulse(3'b001, 15, 10, 638, 1'b0);
    pulse(3'b000, 15, 10, 637, 1'b0);
    pulse(3'b010, 15, 10, 636, 1'b1);
    pulse(3'b010, 15, 10, 635, 1'b0);
    pulse(3'b000, 15, 10, 634, 1'b0);
    pulse(3'b100, 15, 10, 633, 1'b1);
    pulse(3'b100, 15, 10, 632, 1'b0);
    pulse(3'b000, 15, 10, 631, 1'b0);
    pulse(3'b001, 15, 10, 630, 1'b1);

    // Single-layer mask: cur moves to layer 1 without blank or irq, then holds.
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h0B);
    wr(3'd1, 8'h01);
    pulse(3'b010, 15, 10, 630, 1'b0);
    pulse(3'b010, 15, 10, 630, 1'b0);
    pulse(3'b010, 15, 10, 630, 1'b0);

    // DWELL=0 holds the current layer.
    wr(3'd0, 8'h1F);
    wr(3'd1, 8'h00);
    pulse(3'b010, 15, 10, 630, 1'b0);
    pulse(3'b010, 15, 10, 630, 1'b0);

    // Back to manual, SEL=1; speed write coincident with a tick.
    wr(3'd5, 8'h01);
    wr(3'd2, 8'h02);
    wr(3'd0, 8'h01);
    pulse(3'b010, 17, 10, 630, 1'b0);
    pulse(3'b010, 19, 10, 630, 1'b0, 1'b1, 3'd2, 8'h08);
    pulse(3'b010, 27, 10, 630, 1'b0);

    // Drop run while in BLANK: IDLE, offsets held.
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h01);
    wr(3'd0, 8'h1F);
    wr(3'd1, 8'h01);
    pulse(3'b001, 27, 10, 631, 1'b0);
    pulse(3'b000, 27, 10, 632, 1'b0);
    wr(3'd0, 8'h00);
    pulse(3'b000, 27, 10, 632, 1'b0);
    pulse(3'b000, 27, 10, 632, 1'b0);

    // Reset with vsync held high: no tick until vsync falls and rises again.
    @(negedge clk);
    rst = 1'b1; vsync = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL no_tick_after_reset: frame_tick=1 seen, required 0");
    end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    pulse(3'b000, 0, 0, 0, 1'b0);

    repeat (5) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_ticks: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
